// File: rtl/rvlab_clk_drp_rmw_if.sv
// Request/response and MMCM DRP signals of the clock-reconfig read-modify-write sequencer.
// The slave modport is the sequencer's view; master is the requester plus DRP side.
interface rvlab_clk_drp_rmw_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [15:0] req_wdata_i;
    logic [15:0] req_mask_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        drp_den_o;
    logic        drp_dwe_o;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i;
    logic        drp_drdy_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_mask_i,
        input  drp_do_i, drp_drdy_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_mask_i,
        output drp_do_i, drp_drdy_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o
    );
endinterface

// File: rtl/rvlab_clk_drp_rmw.sv
// Read-modify-write sequencer in front of the MMCM DRP port: one request at a time,
// unmapped-address rejection and a bounded wait for DRDY on every access.
module rvlab_clk_drp_rmw #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rvlab_clk_drp_rmw_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          we_q;
    logic [15:0]   wdata_q;
    logic [15:0]   mask_q;
    logic [15:0]   rdata_q;
    logic [6:0]    daddr_q;
    logic [15:0]   di_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic          ready;
    logic          den;
    logic          dwe;
    logic          rsp_valid;
    logic          unmapped;
    logic          timeout;

    // Address 0 is the remapper's "no mapping" code; anything above 7 bits has no DRP register.
    assign unmapped = (bus.req_addr_i == 32'd0) || (bus.req_addr_i[31:7] != 25'd0);
    assign timeout  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        den        = 1'b0;
        dwe        = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid_i) begin
                    state_next = unmapped ? RESP : RD;
                end
            end
            RD: begin
                den        = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.drp_drdy_i) begin
                    state_next = we_q ? WR : RESP;
                end else if (timeout) begin
                    state_next = RESP;
                end
            end
            WR: begin
                den        = 1'b1;
                dwe        = 1'b1;
                state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.drp_drdy_i || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // DRP address and write data only change on the edge that enters their den cycle,
    // so they hold steady for the rest of the sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            wdata_q <= 16'd0;
            mask_q  <= 16'd0;
            rdata_q <= 16'd0;
            daddr_q <= 7'd0;
            di_q    <= 16'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= (state == RD_WAIT || state == WR_WAIT) ? cnt_q + 1'b1 : '0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        we_q    <= bus.req_we_i;
                        wdata_q <= bus.req_wdata_i;
                        mask_q  <= bus.req_mask_i;
                        err_q   <= unmapped;
                        rdata_q <= 16'd0;
                        if (!unmapped) begin
                            daddr_q <= bus.req_addr_i[6:0];
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.drp_drdy_i) begin
                        rdata_q <= bus.drp_do_i;
                        if (we_q) begin
                            di_q <= (bus.drp_do_i & ~mask_q) | (wdata_q & mask_q);
                        end
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 16'd0;
                    end
                end
                WR_WAIT: begin
                    if (!bus.drp_drdy_i && timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = rsp_valid & err_q;
    assign bus.drp_den_o   = den;
    assign bus.drp_dwe_o   = dwe;
    assign bus.drp_daddr_o = daddr_q;
    assign bus.drp_di_o    = di_q;
endmodule

// File: tb/tb_rvlab_clk_drp_rmw.sv
// Bench for rvlab_clk_drp_rmw: a transaction-level model predicts every den pulse and
// response by cycle number; a DRP responder answers each access after a chosen delay.
module tb_rvlab_clk_drp_rmw;
    localparam int TO    = 64;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    rvlab_clk_drp_rmw_if bus ();

    rvlab_clk_drp_rmw #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] rdata;
        logic        err;
    } rsp_exp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } den_exp_t;

    rsp_exp_t rspq[$];
    den_exp_t denq[$];

    int          rd_delay  = NEVER;
    int          wr_delay  = NEVER;
    logic [15:0] rd_value  = 16'h0;

    int          den_count = 0;
    int          wr_count  = 0;
    logic [15:0] last_di   = 16'h0;
    int          last_rsp_cyc = 0;
    logic [15:0] last_rdata = 16'h0;
    logic        last_err   = 1'b0;
    int          last_acc   = 0;

    logic [6:0]  prev_daddr = 7'h0;
    logic [15:0] prev_di    = 16'h0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [15:0] merge_bits(input logic [15:0] old_v, input logic [15:0] new_v,
                                               input logic [15:0] mask);
        logic [15:0] r;
        for (int b = 0; b < 16; b++) r[b] = mask[b] ? new_v[b] : old_v[b];
        return r;
    endfunction

    // Compare process: every cycle, den and response must appear exactly where the model placed them.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_rsp;
            logic exp_den;
            exp_rsp = (rspq.size() > 0) && (rspq[0].cyc == cyc);
            check_output("rsp_valid", {31'd0, bus.rsp_valid_o}, {31'd0, exp_rsp});
            if (exp_rsp) begin
                if (bus.rsp_valid_o) begin
                    check_output("rsp_rdata", {16'd0, bus.rsp_rdata_o}, {16'd0, rspq[0].rdata});
                    check_output("rsp_err", {31'd0, bus.rsp_err_o}, {31'd0, rspq[0].err});
                end
                void'(rspq.pop_front());
            end
            if (bus.rsp_valid_o) begin
                last_rsp_cyc = cyc;
                last_rdata   = bus.rsp_rdata_o;
                last_err     = bus.rsp_err_o;
            end

            exp_den = (denq.size() > 0) && (denq[0].cyc == cyc);
            check_output("drp_den", {31'd0, bus.drp_den_o}, {31'd0, exp_den});
            if (exp_den) begin
                if (bus.drp_den_o) begin
                    check_output("drp_dwe", {31'd0, bus.drp_dwe_o}, {31'd0, denq[0].we});
                    check_output("drp_daddr", {25'd0, bus.drp_daddr_o}, {25'd0, denq[0].addr});
                    if (denq[0].we) check_output("drp_di", {16'd0, bus.drp_di_o}, {16'd0, denq[0].di});
                end
                void'(denq.pop_front());
            end
            if (bus.drp_den_o) begin
                den_count++;
                if (bus.drp_dwe_o) begin
                    wr_count++;
                    last_di = bus.drp_di_o;
                end
            end else begin
                check_output("daddr_hold", {25'd0, bus.drp_daddr_o}, {25'd0, prev_daddr});
                check_output("di_hold", {16'd0, bus.drp_di_o}, {16'd0, prev_di});
                check_output("dwe_without_den", {31'd0, bus.drp_dwe_o}, 32'd0);
            end
        end
        prev_daddr = bus.drp_daddr_o;
        prev_di    = bus.drp_di_o;
    end

    // DRP responder: answers a den pulse after the delay configured for that access type.
    initial begin
        bus.drp_drdy_i = 1'b0;
        bus.drp_do_i   = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.drp_den_o && !rst) begin
                int k;
                logic is_wr;
                is_wr = bus.drp_dwe_o;
                k = is_wr ? wr_delay : rd_delay;
                if (k < NEVER) begin
                    repeat (k) @(posedge clk);
                    #1;
                    bus.drp_drdy_i = 1'b1;
                    bus.drp_do_i   = is_wr ? 16'h5A5A : rd_value;
                    @(posedge clk);
                    #1;
                    bus.drp_drdy_i = 1'b0;
                end
            end
        end
    end

    // Issues one request and records what the model says must follow, relative to the accept cycle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [15:0] wdata,
                         input logic [15:0] mask, input logic [15:0] do_val,
                         input int krd, input int kwr, output int lat);
        int a;
        logic bad;
        rd_delay = krd;
        wr_delay = kwr;
        rd_value = do_val;
        @(negedge clk);
        check_output("req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        bus.req_mask_i  = mask;
        a = cyc;
        last_acc = a;
        bad = (addr == 32'd0) || (addr >= 32'h80);
        if (bad) begin
            lat = 1;
            rspq.push_back('{a + 1, 16'h0, 1'b1});
        end else begin
            denq.push_back('{a + 1, 1'b0, addr[6:0], 16'h0});
            if (krd > TO) begin
                lat = 2 + TO;
                rspq.push_back('{a + lat, 16'h0, 1'b1});
            end else if (!we) begin
                lat = krd + 2;
                rspq.push_back('{a + lat, do_val, 1'b0});
            end else begin
                denq.push_back('{a + krd + 2, 1'b1, addr[6:0], merge_bits(do_val, wdata, mask)});
                if (kwr > TO) begin
                    lat = krd + 3 + TO;
                    rspq.push_back('{a + lat, 16'h0, 1'b1});
                end else begin
                    lat = krd + kwr + 3;
                    rspq.push_back('{a + lat, do_val, 1'b0});
                end
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [15:0] wdata,
                                  input logic [15:0] mask, input logic [15:0] do_val,
                                  input int krd, input int kwr);
        int lat;
        issue(we, addr, wdata, mask, do_val, krd, kwr, lat);
        repeat (lat + 2) @(negedge clk);
    endtask

    initial begin
        int dc;
        int wc;
        int lat;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 32'h0;
        bus.req_wdata_i = 16'h0;
        bus.req_mask_i  = 16'h0;

        repeat (3) @(negedge clk);
        check_output("reset_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check_output("reset_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check_output("reset_rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
        check_output("reset_rsp_rdata", {16'd0, bus.rsp_rdata_o}, 32'd0);
        check_output("reset_den", {31'd0, bus.drp_den_o}, 32'd0);
        check_output("reset_dwe", {31'd0, bus.drp_dwe_o}, 32'd0);
        check_output("reset_daddr", {25'd0, bus.drp_daddr_o}, 32'd0);
        check_output("reset_di", {16'd0, bus.drp_di_o}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] plain read");
        apply_stimulus(1'b0, 32'h08, 16'h0, 16'h0, 16'h1234, 3, NEVER);
        check_output("read_latency", last_rsp_cyc - last_acc, 32'd5);
        check_output("read_rdata_lit", {16'd0, last_rdata}, 32'h1234);

        $display("[TB] read-modify-write");
        wc = wr_count;
        apply_stimulus(1'b1, 32'h09, 16'h0050, 16'h00F0, 16'hABCD, 2, 1);
        check_output("rmw_di_lit", {16'd0, last_di}, 32'hAB5D);
        check_output("rmw_rdata_lit", {16'd0, last_rdata}, 32'hABCD);
        check_output("rmw_write_count", wr_count - wc, 32'd1);
        check_output("rmw_latency", last_rsp_cyc - last_acc, 32'd6);

        $display("[TB] unmapped addresses");
        dc = den_count;
        apply_stimulus(1'b1, 32'h0, 16'hFFFF, 16'hFFFF, 16'h1111, 1, 1);
        check_output("addr0_latency", last_rsp_cyc - last_acc, 32'd1);
        check_output("addr0_err_lit", {31'd0, last_err}, 32'd1);
        apply_stimulus(1'b0, 32'h80, 16'h0, 16'h0, 16'h2222, 1, 1);
        apply_stimulus(1'b1, 32'h8000_0008, 16'h0, 16'hFFFF, 16'h3333, 1, 1);
        check_output("unmapped_no_den", den_count - dc, 32'd0);

        $display("[TB] data patterns");
        apply_stimulus(1'b0, 32'h7F, 16'h0, 16'h0, 16'hFFFF, 1, NEVER);
        apply_stimulus(1'b1, 32'h01, 16'h1357, 16'hFFFF, 16'h2468, 1, 1);
        check_output("mask_all_di_lit", {16'd0, last_di}, 32'h1357);
        apply_stimulus(1'b1, 32'h02, 16'hFFFF, 16'h0000, 16'h0F0F, 4, 2);
        check_output("mask_none_di_lit", {16'd0, last_di}, 32'h0F0F);

        $display("[TB] timeout boundaries");
        apply_stimulus(1'b0, 32'h20, 16'h0, 16'h0, 16'h4321, TO, NEVER);
        check_output("drdy_last_cycle_err", {31'd0, last_err}, 32'd0);
        apply_stimulus(1'b0, 32'h21, 16'h0, 16'h0, 16'h8765, TO + 1, NEVER);
        check_output("drdy_late_err_lit", {31'd0, last_err}, 32'd1);
        wc = wr_count;
        apply_stimulus(1'b0, 32'h10, 16'h0, 16'h0, 16'h9999, NEVER, NEVER);
        check_output("read_timeout_latency", last_rsp_cyc - last_acc, 32'd66);
        apply_stimulus(1'b1, 32'h11, 16'hAAAA, 16'hFFFF, 16'h9999, NEVER, NEVER);
        check_output("rd_timeout_no_write", wr_count - wc, 32'd0);
        apply_stimulus(1'b1, 32'h12, 16'h00FF, 16'h0F0F, 16'hC3C3, 2, NEVER);
        check_output("wr_timeout_rdata_lit", {16'd0, last_rdata}, 32'd0);
        apply_stimulus(1'b0, 32'h08, 16'h0, 16'h0, 16'h0BAD, 2, NEVER);

        $display("[TB] stray drdy in idle");
        @(negedge clk);
        bus.drp_drdy_i = 1'b1;
        bus.drp_do_i   = 16'hFFFF;
        @(negedge clk);
        bus.drp_drdy_i = 1'b0;
        repeat (2) @(negedge clk);
        check_output("stray_ready", {31'd0, bus.req_ready_o}, 32'd1);
        apply_stimulus(1'b0, 32'h33, 16'h0, 16'h0, 16'h7E57, 1, NEVER);

        $display("[TB] reset during write wait");
        issue(1'b1, 32'h0A, 16'h1234, 16'hFF00, 16'h5678, 2, NEVER, lat);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        rspq.delete();
        repeat (3) begin
            @(negedge clk);
            check_output("rst_den", {31'd0, bus.drp_den_o}, 32'd0);
            check_output("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        end
        rst = 1'b0;
        check_output("post_rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check_output("post_rst_daddr", {25'd0, bus.drp_daddr_o}, 32'd0);
        check_output("post_rst_di", {16'd0, bus.drp_di_o}, 32'd0);
        repeat (80) @(negedge clk);
        apply_stimulus(1'b1, 32'h0B, 16'hF000, 16'hF000, 16'h0ABC, 3, 3);
        check_output("post_rst_rmw_di_lit", {16'd0, last_di}, 32'hFABC);

        check_output("rsp_queue_empty", rspq.size(), 32'd0);
        check_output("den_queue_empty", denq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end
endmodule
